// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - debug dump of a register-file address range, MSB byte first, to a UART TX
// Freezes CPU reads via Debug_on while it walks the range one register at a time.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              Debug_on,
  output logic [ADDR_W-1:0] read_regDebug,
  input  logic [DATA_W-1:0] out_regDebug,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] last;
  logic [ADDR_W-1:0] last_clamp;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  byte_cnt;
  logic              last_byte;
  logic              range_ok;

  // An out-of-range last address is pulled back to the top register.
  assign last_clamp = ({1'b0, last_addr} > {1'b0, MAX_ADDR}) ? MAX_ADDR : last_addr;
  assign range_ok   = (first_addr <= last_clamp);
  assign last_byte  = (byte_cnt == LAST_BYTE);

  assign busy          = (state != S_IDLE);
  assign Debug_on      = busy;
  assign tx_start      = (state == S_SEND);
  assign done          = (state == S_DONE);
  assign read_regDebug = addr;
  assign tx_data       = shreg[DATA_W-1 -: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = range_ok ? S_SETUP : S_DONE;
        end
      end
      S_SETUP: state_nxt = S_SEND;
      S_SEND:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          if (!last_byte) begin
            state_nxt = S_SEND;
          end else if (addr == last) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SETUP;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // out_regDebug is only trusted at the end of SETUP, after the falling-edge update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      last     <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr <= first_addr;
            last <= last_clamp;
          end
        end
        S_SETUP: begin
          shreg    <= out_regDebug;
          byte_cnt <= '0;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (!last_byte) begin
              shreg    <= shreg << 8;
              byte_cnt <= byte_cnt + CNT_W'(1);
            end else if (addr != last) begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug-side reader for the register file's debug read port. On a start pulse it freezes normal register reads by raising `Debug_on`, walks `read_regDebug` over a requested address range, captures each 32-bit word from `out_regDebug`, and streams it MSB-byte-first to the UART transmitter through a byte handshake. It sits between the register file and the debug UART TX in the top-level debug unit.

## Interface

- `NUM_REGS`, default 32: number of addressable registers.
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register width. Must be a multiple of 8.

- `clk`  in  1  system clock; this block uses the rising edge only.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to dump a range. Ignored while `busy`=1.
- `first_addr`  in  ADDR_W  first register to dump; sampled when `start` is accepted.
- `last_addr`  in  ADDR_W  last register to dump, inclusive; sampled when `start` is accepted.
- `Debug_on`  out  1  drives the register file's debug-read select.
- `read_regDebug`  out  ADDR_W  debug read address sent to the register file.
- `out_regDebug`  in  DATA_W  debug read data from the register file. The register file updates it on the falling edge of `clk`.
- `tx_data`  out  8  byte for the UART transmitter.
- `tx_start`  out  1  one-cycle pulse meaning `tx_data` is valid.
- `tx_done`  in  1  one-cycle pulse from the UART transmitter when the byte has been sent.
- `busy`  out  1  high from accepting `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse when the dump finishes.

## Operation

- States: IDLE, SETUP, SEND, WAIT, DONE.
- **IDLE**
  - `start`=1 latches `first_addr` into `addr` and `last_addr` into `last`.
  - If `first_addr` ≤ `last_addr`, go to SETUP; otherwise go to DONE and send no bytes.
- **SETUP**
  - Drive `read_regDebug`=`addr`.
  - The register file captures the word on the falling edge inside this cycle.
  - At the closing rising edge, load `shreg` ← `out_regDebug`, clear `byte_cnt`, and go to SEND.
- **SEND**
  - `tx_start`=1 for exactly one cycle, with `tx_data`=`shreg[DATA_W-1:DATA_W-8]`.
  - Go to WAIT.
- **WAIT**
  - Hold `tx_data` stable and wait for `tx_done`.
  - On `tx_done` with `byte_cnt` < DATA_W/8−1: shift `shreg` left by 8, increment `byte_cnt`, go to SEND.
  - On `tx_done` with the last byte sent: if `addr`==`last`, go to DONE; otherwise increment `addr` and go to SETUP.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- `Debug_on` = `busy`. It is held for the whole dump, so the CPU read ports stay frozen.
- `tx_done` outside WAIT is ignored.
- `start` while `busy`=1 is ignored. It is neither queued nor does it restart the dump.
- Address increments never wrap, because termination happens at `addr`==`last` before any increment. `last_addr`=NUM_REGS−1 is legal.

## Timing

- Reset (asynchronous, `rst`=0):
  - state goes to IDLE immediately.
  - `Debug_on`, `busy`, `done`, and `tx_start` go to 0.
  - `tx_data`, `read_regDebug`, `shreg`, and `byte_cnt` go to 0.
- Reset in the middle of a dump aborts it. No `done` pulse is produced, and a `tx_start` in flight is dropped.
- `start` sampled at edge E0:
  - `busy`, `Debug_on`, and `read_regDebug` are valid after E0.
  - The first `tx_start` is high in the cycle after E1, which is 2 cycles of latency.
- `tx_done` sampled to the next `tx_start`:
  - 1 cycle between bytes of the same register.
  - 2 cycles between registers, because a SETUP cycle is inserted.
- Bytes per dump: (`last`−`first`+1)·DATA_W/8. The full default dump is 128 bytes.
- `done` pulses in the cycle after the final `tx_done` is sampled. `busy` and `Debug_on` fall one cycle later.
- Empty range (`first`>`last`): `busy` and `done` are both high in the cycle after E0, and no `tx_start` occurs.
- `out_regDebug` must be sampled only at the end of SETUP. That is the only edge guaranteed to follow the register file's falling-edge update.

## Test plan

- **Single register.** Set `first`=`last`=1 with the register-file model holding 0x00000011, and have `tx_done` respond 3 cycles after each `tx_start`.
  - Required: `tx_data` sequence is 00, 00, 00, 11.
  - Required: exactly one `done`; `Debug_on` is high throughout.
- **Full dump.** Set `first`=0 and `last`=31 with register 31 = 42.
  - Required: 128 `tx_start` pulses.
  - Required: the last four bytes are 00, 00, 00, 2A.
  - Required: `read_regDebug` steps 0..31 with no wrap.
- **Empty range.** Set `first`=5 and `last`=3.
  - Required: `done` 1 cycle after `start`, with no `tx_start`.
- **Spurious handshakes.** Pulse `tx_done` while in IDLE and SETUP, and pulse `start` during WAIT.
  - Required: byte stream and address sequence are unchanged, and no restart occurs.
- **Reset mid-dump.** Assert `rst`=0 during WAIT of register 2, byte 1.
  - Required: all outputs go to 0 at once, with no `done` pulse.
  - Required: a new `start` after reset is released dumps correctly from its own `first_addr`.
- **Latency.** With `tx_done` returned in 1 cycle, check that `start`→first `tx_start` is 2 cycles, the intra-register gap is 1 cycle, and the inter-register gap is 2 cycles.
